// File: rtl/lcd_phy_8080.sv
// Write-only Intel-8080 style parallel LCD PHY: one byte per valid/ready handshake,
// WR_n strobe and CS_n setup/release generated from cycle-count parameters.
module lcd_phy_8080 #(
    parameter int WRL_CYC  = 2,
    parameter int WRH_CYC  = 2,
    parameter int CSS_CYC  = 1,
    parameter int IDLE_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_rs,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] lcd_d,
    output logic       lcd_rs,
    output logic       lcd_wr_n,
    output logic       lcd_cs_n,
    output logic       busy
);

    localparam int MAX_WR  = (WRL_CYC > WRH_CYC) ? WRL_CYC : WRH_CYC;
    localparam int MAX_CS  = (CSS_CYC > IDLE_CYC) ? CSS_CYC : IDLE_CYC;
    localparam int MAX_CYC = (MAX_WR > MAX_CS) ? MAX_WR : MAX_CS;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] CSS_LD  = CW'(CSS_CYC - 1);
    localparam logic [CW-1:0] WRL_LD  = CW'(WRL_CYC - 1);
    localparam logic [CW-1:0] WRH_LD  = CW'(WRH_CYC - 1);
    localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYC - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSS,
        ST_WRL,
        ST_WRH,
        ST_HOLD
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          cnt_zero;

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // in_ready is decoded from state/counter only so it never loops back through in_valid
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_CSS;
                    cnt_nxt   = CSS_LD;
                end
            end
            ST_CSS: begin
                if (cnt_zero) begin
                    state_nxt = ST_WRL;
                    cnt_nxt   = WRL_LD;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            ST_WRL: begin
                if (cnt_zero) begin
                    state_nxt = ST_WRH;
                    cnt_nxt   = WRH_LD;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            ST_WRH: begin
                if (cnt_zero) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        state_nxt = ST_WRL;
                        cnt_nxt   = WRL_LD;
                    end else begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = IDLE_LD;
                    end
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            ST_HOLD: begin
                in_ready = 1'b1;
                // a byte arriving on the final hold cycle keeps the burst open
                if (in_valid) begin
                    state_nxt = ST_WRL;
                    cnt_nxt   = WRL_LD;
                end else if (cnt_zero) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_d  <= 8'h00;
            lcd_rs <= 1'b0;
        end else if (in_valid && in_ready) begin
            lcd_d  <= in_data;
            lcd_rs <= in_rs;
        end
    end

    // Pin levels decode straight from the async-reset state register, so reset releases them at once
    assign lcd_wr_n = (state != ST_WRL);
    assign lcd_cs_n = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_phy_8080.sv
// Self-checking bench for lcd_phy_8080: reference vectors, directed corner sequences
// and randomized traffic against a burst-timeline model.
module tb_lcd_phy_8080;

    localparam int WRL = 2;
    localparam int WRH = 2;
    localparam int CSS = 1;
    localparam int IDL = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_rs = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] lcd_d;
    logic       lcd_rs;
    logic       lcd_wr_n;
    logic       lcd_cs_n;
    logic       busy;

    always #5 clk = ~clk;

    lcd_phy_8080 #(
        .WRL_CYC (WRL),
        .WRH_CYC (WRH),
        .CSS_CYC (CSS),
        .IDLE_CYC(IDL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_rs   (in_rs),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .lcd_d   (lcd_d),
        .lcd_rs  (lcd_rs),
        .lcd_wr_n(lcd_wr_n),
        .lcd_cs_n(lcd_cs_n),
        .busy    (busy)
    );

    int checks = 0;
    int failures = 0;

    // Timeline model: each accepted byte fixes its strobe window, the earliest
    // next-accept cycle and the cycle at which chip select would be released.
    int       m_cyc, m_lo_s, m_lo_e, m_rdy_from, m_rel_at;
    logic [7:0] m_d;
    logic     m_rs;

    logic       obs_wr, obs_cs, obs_rdy, obs_busy, obs_rs;
    logic [7:0] obs_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, m_cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc      = 0;
        m_lo_s     = -100;
        m_lo_e     = -100;
        m_rdy_from = 0;
        m_rel_at   = 0;
        m_d        = 8'h00;
        m_rs       = 1'b0;
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle against the model, advances past the edge
    task automatic do_cycle(input logic v, input logic [7:0] d, input logic r);
        logic er, ecs, ewr;
        in_valid = v;
        in_data  = d;
        in_rs    = r;
        @(negedge clk);
        er  = (m_cyc >= m_rdy_from);
        ecs = (m_cyc >= m_rel_at);
        ewr = !(m_cyc >= m_lo_s && m_cyc <= m_lo_e);
        chk("m_ready", 32'(in_ready), 32'(er));
        chk("m_cs_n",  32'(lcd_cs_n), 32'(ecs));
        chk("m_busy",  32'(busy),     32'(!ecs));
        chk("m_wr_n",  32'(lcd_wr_n), 32'(ewr));
        chk("m_d",     32'(lcd_d),    32'(m_d));
        chk("m_rs",    32'(lcd_rs),   32'(m_rs));
        obs_wr = lcd_wr_n; obs_cs = lcd_cs_n; obs_rdy = in_ready;
        obs_busy = busy; obs_d = lcd_d; obs_rs = lcd_rs;
        if (v && er) begin
            m_lo_s     = m_cyc + 1 + (ecs ? CSS : 0);
            m_lo_e     = m_lo_s + WRL - 1;
            m_rdy_from = m_lo_e + WRH;
            m_rel_at   = m_rdy_from + IDL + 1;
            m_d        = d;
            m_rs       = r;
        end
        @(posedge clk);
        #1;
        m_cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 8'h00, 1'b0);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rs;
        logic       e_cs;
        logic       e_wr;
        logic       e_rdy;
        logic       e_busy;
        logic [7:0] e_d;
    } vec_t;

    vec_t tbl[16];

    logic [7:0] sb[4];
    logic       sr[4];

    initial begin
        // single byte 0x2A from idle, accepted at cycle 0
        for (int i = 0; i < 16; i++) begin
            tbl[i].v      = (i == 0);
            tbl[i].d      = 8'h2A;
            tbl[i].rs     = 1'b0;
            tbl[i].e_cs   = (i == 0 || i >= 14);
            tbl[i].e_wr   = !(i == 2 || i == 3);
            tbl[i].e_rdy  = (i == 0 || i >= 5);
            tbl[i].e_busy = !(i == 0 || i >= 14);
            tbl[i].e_d    = (i == 0) ? 8'h00 : 8'h2A;
        end
        sb[0] = 8'h2C; sb[1] = 8'h11; sb[2] = 8'h22; sb[3] = 8'h33;
        sr[0] = 1'b0;  sr[1] = 1'b1;  sr[2] = 1'b1;  sr[3] = 1'b1;

        // reset held with valid asserted
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_rs    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n",  32'(lcd_cs_n), 32'(1));
        chk("rst_wr_n",  32'(lcd_wr_n), 32'(1));
        chk("rst_d",     32'(lcd_d),    32'(8'h00));
        chk("rst_rs",    32'(lcd_rs),   32'(0));
        chk("rst_ready", 32'(in_ready), 32'(1));
        chk("rst_busy",  32'(busy),     32'(0));
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 16; i++) begin
            do_cycle(tbl[i].v, tbl[i].d, tbl[i].rs);
            chk("tbl_cs_n",  32'(obs_cs),   32'(tbl[i].e_cs));
            chk("tbl_wr_n",  32'(obs_wr),   32'(tbl[i].e_wr));
            chk("tbl_ready", 32'(obs_rdy),  32'(tbl[i].e_rdy));
            chk("tbl_busy",  32'(obs_busy), 32'(tbl[i].e_busy));
            chk("tbl_d",     32'(obs_d),    32'(tbl[i].e_d));
        end

        // streaming four bytes with valid held high
        begin
            int   idx;
            int   rises[$];
            int   cs_hi;
            logic prev;
            idx = 0; cs_hi = 0; prev = 1'b1;
            for (int c = 0; c < 30; c++) begin
                if (idx < 4) do_cycle(1'b1, sb[idx], sr[idx]);
                else         do_cycle(1'b0, 8'h00, 1'b0);
                if (idx < 4 && obs_rdy) idx++;
                if (prev == 1'b0 && obs_wr == 1'b1) rises.push_back(c);
                prev = obs_wr;
                if (c >= 1 && c <= 25 && obs_cs) cs_hi++;
            end
            chk("stream_rises", 32'(rises.size()), 32'(4));
            for (int i = 1; i < rises.size(); i++)
                chk("stream_gap", 32'(rises[i] - rises[i-1]), 32'(WRL + WRH));
            chk("stream_cs_low", 32'(cs_hi), 32'(0));
        end

        // second byte presented 5 cycles after the first byte's WRH ends
        for (int c = 0; c < 24; c++) begin
            do_cycle(c == 0 || c == 10, (c == 0) ? 8'h3C : 8'hC3, c == 10);
            if (c == 10) chk("gap_cs_n", 32'(obs_cs), 32'(0));
            if (c == 11) begin
                chk("gap_no_css_wr", 32'(obs_wr), 32'(0));
                chk("gap_cs_hold",   32'(obs_cs), 32'(0));
                chk("gap_d",         32'(obs_d),  32'(8'hC3));
            end
        end
        drain();

        // valid on the last HOLD cycle, then valid one cycle after timeout
        for (int c = 0; c < 32; c++) begin
            do_cycle(c == 0 || c == 13 || c == 26, 8'(c + 1), 1'b0);
            if (c == 13) chk("tmo_last_hold_cs", 32'(obs_cs), 32'(0));
            if (c == 14) begin
                chk("tmo_accept_cs", 32'(obs_cs), 32'(0));
                chk("tmo_accept_wr", 32'(obs_wr), 32'(0));
            end
            if (c == 26) chk("tmo_late_cs_hi", 32'(obs_cs), 32'(1));
            if (c == 27) begin
                chk("tmo_late_css_cs", 32'(obs_cs), 32'(0));
                chk("tmo_late_css_wr", 32'(obs_wr), 32'(1));
            end
            if (c == 28) chk("tmo_late_wrl", 32'(obs_wr), 32'(0));
        end
        drain();

        // randomized traffic with changing density
        begin
            int dens;
            dens = 50;
            for (int c = 0; c < 600; c++) begin
                if (c % 60 == 0) begin
                    case ($urandom_range(0, 3))
                        0: dens = 95;
                        1: dens = 40;
                        2: dens = 12;
                        default: dens = 3;
                    endcase
                end
                do_cycle($urandom_range(0, 99) < dens, 8'($urandom), 1'($urandom));
            end
        end
        drain();

        // async reset in the middle of a strobe
        do_cycle(1'b1, 8'h55, 1'b1);
        do_cycle(1'b0, 8'h00, 1'b0);
        chk("ar_wrl_before", 32'(lcd_wr_n), 32'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_wr_n", 32'(lcd_wr_n), 32'(1));
        chk("ar_cs_n", 32'(lcd_cs_n), 32'(1));
        chk("ar_busy", 32'(busy),     32'(0));
        chk("ar_d",    32'(lcd_d),    32'(8'h00));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        do_cycle(1'b1, 8'h66, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0);
        chk("ar_css_cs", 32'(obs_cs), 32'(0));
        chk("ar_css_wr", 32'(obs_wr), 32'(1));
        do_cycle(1'b0, 8'h00, 1'b0);
        chk("ar_wrl_wr", 32'(obs_wr), 32'(0));
        chk("ar_new_d",  32'(obs_d),  32'(8'h66));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_phy_8080.md
Name: lcd_phy_8080

Overview:
- Write-only Intel-8080-style parallel LCD PHY. Sits directly downstream of the LCD PHY arbitration mux.
- Consumes one byte per valid/ready handshake (data + RS) and drives the panel pins: D[7:0], RS, WR_n, CS_n.
- Generates WR_n strobe timing and chip-select setup/release from cycle-count parameters. Back-to-back bytes stream at one strobe per WRL_CYC+WRH_CYC cycles.

Parameters:
- WRL_CYC, 2, cycles WR_n held low per byte (>=1)
- WRH_CYC, 2, cycles WR_n held high after each byte (>=1)
- CSS_CYC, 1, cycles CS_n low before first WR_n fall of a burst (>=1)
- IDLE_CYC, 8, cycles without valid before CS_n is released (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  byte to send
- in_rs  in  1  register-select for byte (0=command, 1=data)
- in_valid  in  1  byte available
- in_ready  out  1  byte accepted this cycle when in_valid & in_ready
- lcd_d  out  8  panel data bus (registered)
- lcd_rs  out  1  panel RS (registered)
- lcd_wr_n  out  1  panel write strobe, data latched by panel on rising edge
- lcd_cs_n  out  1  panel chip select
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset, async on rst_n low: state=IDLE, lcd_wr_n=1, lcd_cs_n=1, lcd_d=0x00, lcd_rs=0, counter=0. Reset mid-strobe aborts immediately; the partial byte is dropped.
- States:
  - IDLE: CS_n=1, WR_n=1.
  - CSS: CS_n=0, WR_n=1.
  - WRL: CS_n=0, WR_n=0.
  - WRH: CS_n=0, WR_n=1.
  - HOLD: CS_n=0, WR_n=1, waiting for the next byte.
- in_ready is combinational: 1 in IDLE, 1 in HOLD, 1 in the last WRH cycle (counter==0); 0 otherwise. It never depends on in_valid.
- On accept, in_data and in_rs are registered into lcd_d/lcd_rs on the same clock edge. Registered values stay stable until the next accept.
- Transitions:
  - IDLE, accept: go to CSS, counter=CSS_CYC-1.
  - CSS: at counter==0 go to WRL, counter=WRL_CYC-1.
  - WRL: at counter==0 go to WRH, counter=WRH_CYC-1.
  - WRH, counter==0, accept: go to WRL, counter=WRL_CYC-1. Back-to-back path; no CSS.
  - WRH, counter==0, no valid: go to HOLD, counter=IDLE_CYC-1.
  - HOLD, accept: go to WRL, counter=WRL_CYC-1.
  - HOLD, no valid, counter==0: go to IDLE (CS_n rises next cycle).
  - HOLD, no valid, counter!=0: decrement counter.
  - Otherwise the counter decrements by 1 per cycle.
- Accept in HOLD on the same cycle the counter reaches 0: accept wins, CS_n stays low.
- Timing guarantees:
  - Data/RS set up for WRL_CYC cycles before the WR_n rising edge.
  - Data held WRH_CYC cycles after it.
  - Data changes only while WR_n is high.
  - CS_n falls CSS_CYC+WRL_CYC cycles before the first WR_n rising edge.
  - CS_n never toggles while WR_n is low.
- RS may change between bytes within one CS burst.
- Counter width: $clog2 of the largest parameter, plus 1. No wrap: the counter is always reloaded before it underflows.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> lcd_cs_n=1, lcd_wr_n=1, lcd_d=0x00, in_ready=1, busy=0. Release -> first accept occurs on the first clock edge.
- Single byte 0x2A rs=0 (defaults):
  - Accept at cycle 0 -> CS_n low from cycle 1, WR_n low cycles 2-3, high from cycle 4.
  - lcd_d=0x2A, lcd_rs=0 from cycle 1.
  - HOLD cycles 6-13, CS_n high from cycle 14.
- Streaming 0x2C, 0x11, 0x22, 0x33 (rs=0,1,1,1), in_valid held high:
  - WR_n rising edges exactly 4 cycles apart.
  - CS_n stays low throughout.
  - Each byte appears on lcd_d only while WR_n is high.
- Gap inside the idle window: second byte presented 5 cycles after the first's WRH ends -> no CS_n rise, no CSS phase, straight to WRL.
- Timeout edge: valid presented exactly on the last HOLD cycle -> accepted, CS_n stays low. One cycle later instead -> CS_n high for one cycle, then CSS.
- Async reset asserted during WRL of byte 0x55 -> WR_n and CS_n go high in the same cycle without waiting for a clock edge. After release, the next byte starts from IDLE with a full CSS phase.
